prog_sequencer: RTL and testbench

Run-control sequencer for the 9-bit-instruction core's program counter unit. Accepts a start request from the testbench or host, loads the selected program's base address into the PC unit through its reset/load path, then drives the PC unit's branch controls each cycle: advance, branch redirect, or freeze while the datapath stalls. On the PC unit's halt indication it reports completion with a cycle count and returns to idle.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/prog_sequencer_run_counter.sv | 27 ++
 rtl/prog_sequencer.sv | 154 +++++++++++++++
 tb/tb_prog_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the program run-control sequencer.
//
// Contents:
//   seq_state_t    - sequencer states IDLE, LOAD, RUN, DONE
//   PROG_BASE      - base instruction address of each selectable program
//   SEL_ERR_PERIOD - cycles between sel_err pulses while a bad request is held
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int unsigned PROG_BASE [4] = '{0, 128, 256, 384};

  localparam int unsigned SEL_ERR_PERIOD = 4;

endpackage

// File: rtl/prog_sequencer_run_counter.sv
// Saturating run-cycle counter.
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high; clears the count
//   clear  in  synchronous clear, used when a new run is launched
//   enable in  count this cycle
//   count  out current count; sticks at all-ones instead of wrapping
module run_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Run-control sequencer for the 9-bit-instruction core's PC unit.
//
// A start request with a valid program index loads that program's base
// address into the PC unit (one LOAD cycle), then each RUN cycle tells the PC
// unit to increment, redirect to a branch target, or hold during a stall.
// A halt from the PC unit ends the run; done stays high until start drops.
//
// Optional feature: define SEQ_STEP_EN to add single-step control
// (input step, output step_wait). Without it the sequencer free-runs.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   start, prog_sel          run request (level) and program index
//   busy, done, sel_err      status: LOAD/RUN, DONE, bad-index pulse
//   run_cycles               RUN cycles of the last/current run
//   stall                    datapath stall, PC must hold
//   dec_branch, dec_take     decoded branch and its condition
//   dec_target               branch target address
//   pc_halt                  halt flag from PC unit
//   pc_reset, pc_addr        PC load strobe and load/branch address
//   ctrl_branch, take_branch PC control: hold/redirect vs increment
//   step, step_wait          (SEQ_STEP_EN only) step enable and wait status
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int INST_WIDTH = 9,
  parameter int NUM_PROGS  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            prog_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  sel_err,
  output logic [CNT_WIDTH-1:0]  run_cycles,
  input  logic                  stall,
  input  logic                  dec_branch,
  input  logic                  dec_take,
  input  logic [INST_WIDTH-1:0] dec_target,
  input  logic                  pc_halt,
  output logic                  pc_reset,
  output logic [INST_WIDTH-1:0] pc_addr,
  output logic                  ctrl_branch,
  output logic                  take_branch
`ifdef SEQ_STEP_EN
  ,
  input  logic                  step,
  output logic                  step_wait
`endif
);

  localparam int ERR_W = $clog2(SEL_ERR_PERIOD);

  seq_state_t state, state_next;
  logic [INST_WIDTH-1:0] base_q;
  logic [ERR_W-1:0]      err_cnt;
  logic                  sel_valid;
  logic                  launch;
  logic                  bad_req;
  logic                  step_ok;
  logic                  count_en;

  // Zero-extend so the compare is well defined for NUM_PROGS up to 4.
  assign sel_valid = {1'b0, prog_sel} < 3'(NUM_PROGS);
  assign launch    = (state == IDLE) && start && sel_valid;
  assign bad_req   = (state == IDLE) && start && !sel_valid;

`ifdef SEQ_STEP_EN
  assign step_ok   = step;
  assign step_wait = (state == RUN) && !step;
`else
  assign step_ok   = 1'b1;
`endif

  assign busy     = (state == LOAD) || (state == RUN);
  assign done     = (state == DONE);
  assign count_en = (state == RUN) && step_ok;

  // State register, latched base address and the sel_err pulse generator.
  // err_cnt runs modulo SEL_ERR_PERIOD while a bad request is held so the
  // pulse repeats every SEL_ERR_PERIOD cycles, restarting when start drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      base_q  <= '0;
      err_cnt <= '0;
      sel_err <= 1'b0;
    end else begin
      state <= state_next;
      if (launch) begin
        base_q <= INST_WIDTH'(PROG_BASE[prog_sel]);
      end
      if (bad_req) begin
        sel_err <= (err_cnt == '0);
        err_cnt <= (err_cnt == ERR_W'(SEL_ERR_PERIOD - 1)) ? '0 : err_cnt + ERR_W'(1);
      end else begin
        sel_err <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

  // Next state and PC-unit controls. The default is "hold" (ctrl_branch=1,
  // take_branch=0), which covers IDLE, DONE, stalls, step waits and the halt
  // cycle. pc_halt is not looked at in LOAD: the flag may be stale from the
  // previous program until the PC unit processes the load.
  always_comb begin
    state_next  = state;
    pc_reset    = 1'b0;
    pc_addr     = '0;
    ctrl_branch = 1'b1;
    take_branch = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_next = LOAD;
      end
      LOAD: begin
        pc_reset   = 1'b1;
        pc_addr    = base_q;
        state_next = RUN;
      end
      RUN: begin
        if (pc_halt) begin
          state_next = DONE;
        end else if (stall || !step_ok) begin
          ctrl_branch = 1'b1;
        end else if (dec_branch) begin
          ctrl_branch = 1'b1;
          take_branch = dec_take;
          pc_addr     = dec_target;
        end else begin
          ctrl_branch = 1'b0;
        end
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  run_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_run_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (launch),
    .enable (count_en),
    .count  (run_cycles)
  );

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer (default build, SEQ_STEP_EN off).
// The driver pushes one expected-output record per cycle into a queue; a
// monitor pops and compares on the falling edge of the same cycle.
module tb_prog_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  prog_sel;
  logic        busy;
  logic        done;
  logic        sel_err;
  logic [15:0] run_cycles;
  logic        stall;
  logic        dec_branch;
  logic        dec_take;
  logic [8:0]  dec_target;
  logic        pc_halt;
  logic        pc_reset;
  logic [8:0]  pc_addr;
  logic        ctrl_branch;
  logic        take_branch;
`ifdef SEQ_STEP_EN
  logic        step;
  logic        step_wait;
  assign step = 1'b1;
`endif

  prog_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_sel    (prog_sel),
    .busy        (busy),
    .done        (done),
    .sel_err     (sel_err),
    .run_cycles  (run_cycles),
    .stall       (stall),
    .dec_branch  (dec_branch),
    .dec_take    (dec_take),
    .dec_target  (dec_target),
    .pc_halt     (pc_halt),
    .pc_reset    (pc_reset),
    .pc_addr     (pc_addr),
    .ctrl_branch (ctrl_branch),
    .take_branch (take_branch)
`ifdef SEQ_STEP_EN
    ,
    .step        (step),
    .step_wait   (step_wait)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed output layout: {busy, done, sel_err, pc_reset, ctrl_branch,
  // take_branch, pc_addr[8:0], run_cycles[15:0]}.
  localparam logic [30:0] M_ALL   = 31'h7FFF_FFFF;
  localparam logic [30:0] M_CB    = 31'h0400_0000;
  localparam logic [30:0] M_TB    = 31'h0200_0000;
  localparam logic [30:0] M_ADDR  = 31'h01FF_0000;
  localparam logic [30:0] M_NOADR = M_ALL & ~M_ADDR;
  localparam logic [30:0] M_LOAD  = M_ALL & ~(M_CB | M_TB);
  localparam logic [30:0] M_NOCTL = M_ALL & ~(M_CB | M_TB | M_ADDR);
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    string       name;
    logic [30:0] mask;
    logic [30:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [30:0] pk(input logic b, input logic d, input logic er,
                                     input logic r, input logic c, input logic t,
                                     input logic [8:0] a, input logic [15:0] n);
    return {b, d, er, r, c, t, a, n};
  endfunction

  // Drives one cycle of inputs just after the rising edge and queues the
  // outputs expected for that same cycle.
  task automatic applyStimulus(input string nm, input logic rst, input logic st,
                               input logic [1:0] sel, input logic stl, input logic br,
                               input logic tk, input logic [8:0] tgt, input logic hlt,
                               input logic [30:0] msk, input logic [30:0] ex);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    start      = st;
    prog_sel   = sel;
    stall      = stl;
    dec_branch = br;
    dec_take   = tk;
    dec_target = tgt;
    pc_halt    = hlt;
    e.name  = nm;
    e.mask  = msk;
    e.value = ex;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [30:0] obs;
    obs = pk(busy, done, sel_err, pc_reset, ctrl_branch, take_branch, pc_addr, run_cycles);
    n_vec++;
    if (((obs ^ e.value) & e.mask) != '0) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h (mask %h)", e.name, obs & e.mask,
               e.value & e.mask, e.mask);
    end
  endtask

  // Monitor: compare whenever an expectation is waiting for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; prog_sel = 2'd0; stall = 1'b0;
    dec_branch = 1'b0; dec_take = 1'b0; dec_target = 9'd0; pc_halt = 1'b0;

    // Reset and launch of program 1 (base 128)
    applyStimulus("reset_state", H, L, 2'd0, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd0));
    applyStimulus("idle_pre_start", L, H, 2'd1, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd0));
    applyStimulus("load_prog1", L, H, 2'd1, L, L, L, 9'd0, L, M_LOAD, pk(H,L,L,H,L,L,9'd128,16'd0));
    applyStimulus("run_first_inc", L, H, 2'd1, L, L, L, 9'd0, L, M_NOADR, pk(H,L,L,L,L,L,9'd0,16'd0));

    // Branches
    applyStimulus("branch_taken", L, H, 2'd1, L, H, H, 9'd200, L, M_ALL, pk(H,L,L,L,H,H,9'd200,16'd1));
    applyStimulus("branch_not_taken", L, H, 2'd1, L, H, L, 9'd200, L, M_ALL, pk(H,L,L,L,H,L,9'd200,16'd2));

    // Stall beats a simultaneous branch; cycles still counted
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("stall_over_branch_%0d", i), L, H, 2'd1, H, H, H, 9'd50, L,
                    M_NOADR, pk(H,L,L,L,H,L,9'd0,16'(3 + i)));
    end
    applyStimulus("run_after_stall", L, H, 2'd1, L, L, L, 9'd0, L, M_NOADR, pk(H,L,L,L,L,L,9'd0,16'd6));

    // start dropping mid-run is ignored
    applyStimulus("start_drop_run_a", L, L, 2'd1, L, L, L, 9'd0, L, M_NOADR, pk(H,L,L,L,L,L,9'd0,16'd7));
    applyStimulus("start_drop_run_b", L, L, 2'd1, L, L, L, 9'd0, L, M_NOADR, pk(H,L,L,L,L,L,9'd0,16'd8));

    // Halt in the 10th RUN cycle, together with stall and branch
    applyStimulus("halt_cycle", L, H, 2'd1, H, H, H, 9'd77, H, M_NOCTL, pk(H,L,L,L,L,L,9'd0,16'd9));
    applyStimulus("done_after_halt", L, H, 2'd1, L, L, L, 9'd0, L, M_ALL, pk(L,H,L,L,H,L,9'd0,16'd10));
    applyStimulus("done_held", L, H, 2'd1, L, L, L, 9'd0, H, M_ALL, pk(L,H,L,L,H,L,9'd0,16'd10));
    applyStimulus("done_start_low", L, L, 2'd1, L, L, L, 9'd0, L, M_ALL, pk(L,H,L,L,H,L,9'd0,16'd10));
    applyStimulus("idle_after_done", L, L, 2'd1, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd10));

    // Invalid program index: pulse, then repeat four cycles later
    applyStimulus("bad_sel_first", L, H, 2'd3, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd10));
    applyStimulus("sel_err_pulse", L, H, 2'd3, L, L, L, 9'd0, L, M_ALL, pk(L,L,H,L,H,L,9'd0,16'd10));
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("sel_err_gap_%0d", i), L, H, 2'd3, L, L, L, 9'd0, L,
                    M_ALL, pk(L,L,L,L,H,L,9'd0,16'd10));
    end
    applyStimulus("sel_err_repeat", L, H, 2'd3, L, L, L, 9'd0, L, M_ALL, pk(L,L,H,L,H,L,9'd0,16'd10));
    applyStimulus("sel_err_end", L, L, 2'd3, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd10));

    // pc_halt outside RUN is ignored
    applyStimulus("halt_in_idle", L, L, 2'd0, L, L, L, 9'd0, H, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd10));
    applyStimulus("idle_ignores_halt", L, L, 2'd0, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd10));

    // Program 2 with a stale halt during LOAD, then reset mid-run
    applyStimulus("idle_start_prog2", L, H, 2'd2, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd10));
    applyStimulus("load_prog2", L, H, 2'd2, L, L, L, 9'd0, H, M_LOAD, pk(H,L,L,H,L,L,9'd256,16'd0));
    applyStimulus("run_after_load_halt", L, H, 2'd2, L, L, L, 9'd0, L, M_NOADR, pk(H,L,L,L,L,L,9'd0,16'd0));
    applyStimulus("run_prog2_b", L, H, 2'd2, L, L, L, 9'd0, L, M_NOADR, pk(H,L,L,L,L,L,9'd0,16'd1));
    applyStimulus("reset_asserted_run", H, H, 2'd2, L, L, L, 9'd0, L, M_NOADR, pk(H,L,L,L,L,L,9'd0,16'd2));
    applyStimulus("after_mid_reset", L, L, 2'd0, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd0));
    applyStimulus("idle_after_reset", L, L, 2'd0, L, L, L, 9'd0, L, M_ALL, pk(L,L,L,L,H,L,9'd0,16'd0));

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
